// File: rtl/rgb_frame_reader_if.sv
// ============================================================================
//  Module      : rgb_frame_reader_if
//  Description : Bundles the SRAM read bus and the pixel stream handshake of
//                the RGB frame reader. The master modport is the reader; the
//                slave modport is the SRAM plus downstream pixel consumer.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

interface rgb_frame_reader_if;
  logic [17:0] SRAM_address;
  logic        SRAM_we_n;
  logic [15:0] SRAM_read_data;
  logic [7:0]  pixel_R;
  logic [7:0]  pixel_G;
  logic [7:0]  pixel_B;
  logic        pixel_valid;
  logic        pixel_ready;

  modport master (
    output SRAM_address,
    output SRAM_we_n,
    input  SRAM_read_data,
    output pixel_R,
    output pixel_G,
    output pixel_B,
    output pixel_valid,
    input  pixel_ready
  );

  modport slave (
    input  SRAM_address,
    input  SRAM_we_n,
    output SRAM_read_data,
    input  pixel_R,
    input  pixel_G,
    input  pixel_B,
    input  pixel_valid,
    output pixel_ready
  );
endinterface

`default_nettype wire

// File: rtl/rgb_frame_reader.sv
// ============================================================================
//  Module      : rgb_frame_reader
//  Description : Streams one RGB frame out of SRAM. Words are fetched in
//                ascending order into a small FIFO (reads throttled so the
//                FIFO can never overflow), then unpacked three words per two
//                pixels onto a valid/ready pixel stream.
//                Optional build macro RGB_READER_CKSUM_EN adds a 16-bit
//                checksum port summing every word written into the FIFO.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module rgb_frame_reader #(
  parameter logic [17:0] RGB_BASE   = 18'd146944,
  parameter int          NUM_PIXELS = 76800,
  parameter int          FIFO_DEPTH = 8
) (
  input  wire logic          Clock,
  input  wire logic          reset,
  input  wire logic          start,
  rgb_frame_reader_if.master bus,
  output logic               busy,
  output logic               frame_done
`ifdef RGB_READER_CKSUM_EN
  , output logic [15:0]      checksum
`endif
);

  localparam int TOTAL_WORDS = 3 * NUM_PIXELS / 2;
  localparam int WCW         = $clog2(TOTAL_WORDS + 1);
  localparam int PCW         = $clog2(NUM_PIXELS + 1);
  localparam int AW          = $clog2(FIFO_DEPTH);
  localparam int OCW         = AW + 1;
  localparam int SUMW        = AW + 2;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FETCH = 2'd1,
    S_DRAIN = 2'd2,
    S_DONE  = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic            busy_q, busy_d;
  logic            frame_done_q, frame_done_d;

  logic [17:0]     addr_q, addr_d;
  logic [WCW-1:0]  words_q, words_d;
  logic [1:0]      flight_q, flight_d;

  logic [15:0]     fifo_mem_q [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [OCW-1:0]  fifo_cnt_q, fifo_cnt_d;

  logic [7:0]      pix_r_q, pix_r_d;
  logic [7:0]      pix_g_q, pix_g_d;
  logic [7:0]      pix_b_q, pix_b_d;
  logic            pix_valid_q, pix_valid_d;
  logic            odd_q, odd_d;
  logic [PCW-1:0]  pix_cnt_q, pix_cnt_d;

  logic            start_acc;
  logic [SUMW-1:0] occ_plus_flight;
  logic            issue;
  logic            last_issue;
  logic            fifo_wr;
  logic [15:0]     head0;
  logic [15:0]     head1;
  logic            in_stream;
  logic            load;
  logic            hs;
  logic            last_hs;
  logic [1:0]      pops;

  // Read issue: the first read goes out in the same cycle the start is
  // accepted so the first pixel lands early; afterwards reads are only
  // issued while buffered plus in-flight words leave room in the FIFO.
  always_comb begin
    start_acc       = start && (state_q == S_IDLE);
    occ_plus_flight = SUMW'(fifo_cnt_q) + SUMW'(flight_q[0]) + SUMW'(flight_q[1]);
    issue           = ((state_q == S_FETCH) || start_acc)
                      && (words_q < WCW'(TOTAL_WORDS))
                      && (occ_plus_flight < SUMW'(FIFO_DEPTH));
    last_issue      = issue && (words_q == WCW'(TOTAL_WORDS - 1));
    addr_d          = addr_q;
    words_d         = words_q;
    if (issue) begin
      addr_d  = RGB_BASE + 18'(words_q);
      words_d = words_q + WCW'(1);
    end
    if (state_q == S_DONE) begin
      words_d = '0;
    end
    // Stage 0 = address on the bus, stage 1 = its data on SRAM_read_data.
    flight_d = {flight_q[0], issue};
  end

  // FIFO bookkeeping and pixel unpacking. Every pixel needs two words at the
  // FIFO head: an even pixel consumes one word and peeks the next, an odd
  // pixel consumes both.
  always_comb begin
    fifo_wr     = flight_q[1];
    head0       = fifo_mem_q[rd_ptr_q];
    head1       = fifo_mem_q[rd_ptr_q + AW'(1)];
    hs          = pix_valid_q && bus.pixel_ready;
    in_stream   = (state_q == S_FETCH) || (state_q == S_DRAIN);
    load        = in_stream && (!pix_valid_q || bus.pixel_ready)
                  && (fifo_cnt_q >= OCW'(2));
    pops        = 2'd0;
    pix_r_d     = pix_r_q;
    pix_g_d     = pix_g_q;
    pix_b_d     = pix_b_q;
    pix_valid_d = pix_valid_q;
    odd_d       = odd_q;
    if (load) begin
      pix_valid_d = 1'b1;
      odd_d       = !odd_q;
      if (odd_q) begin
        pix_r_d = head0[7:0];
        pix_g_d = head1[15:8];
        pix_b_d = head1[7:0];
        pops    = 2'd2;
      end else begin
        pix_r_d = head0[15:8];
        pix_g_d = head0[7:0];
        pix_b_d = head1[15:8];
        pops    = 2'd1;
      end
    end else if (hs) begin
      pix_valid_d = 1'b0;
    end
    wr_ptr_d   = wr_ptr_q + AW'(fifo_wr);
    rd_ptr_d   = rd_ptr_q + AW'(pops);
    fifo_cnt_d = fifo_cnt_q + OCW'(fifo_wr) - OCW'(pops);
    pix_cnt_d  = pix_cnt_q + PCW'(hs);
    last_hs    = hs && (pix_cnt_q == PCW'(NUM_PIXELS - 1));
    if (state_q == S_DONE) begin
      pix_cnt_d = '0;
      odd_d     = 1'b0;
    end
  end

  // Frame control: next state plus the registered busy / frame_done outputs.
  always_comb begin
    state_d      = state_q;
    busy_d       = busy_q;
    frame_done_d = frame_done_q;
    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          busy_d  = 1'b1;
        end
      end
      S_FETCH: begin
        if (last_issue) begin
          state_d = S_DRAIN;
        end
      end
      S_DRAIN: begin
        if (last_hs) begin
          state_d      = S_DONE;
          frame_done_d = 1'b1;
        end
      end
      S_DONE: begin
        state_d      = S_IDLE;
        busy_d       = 1'b0;
        frame_done_d = 1'b0;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State register for the whole datapath; reset abandons any frame and
  // drops in-flight reads so their data never reaches the FIFO.
  always_ff @(posedge Clock) begin
    if (reset) begin
      state_q      <= S_IDLE;
      busy_q       <= 1'b0;
      frame_done_q <= 1'b0;
      addr_q       <= '0;
      words_q      <= '0;
      flight_q     <= '0;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      fifo_cnt_q   <= '0;
      pix_r_q      <= '0;
      pix_g_q      <= '0;
      pix_b_q      <= '0;
      pix_valid_q  <= 1'b0;
      odd_q        <= 1'b0;
      pix_cnt_q    <= '0;
    end else begin
      state_q      <= state_d;
      busy_q       <= busy_d;
      frame_done_q <= frame_done_d;
      addr_q       <= addr_d;
      words_q      <= words_d;
      flight_q     <= flight_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      fifo_cnt_q   <= fifo_cnt_d;
      pix_r_q      <= pix_r_d;
      pix_g_q      <= pix_g_d;
      pix_b_q      <= pix_b_d;
      pix_valid_q  <= pix_valid_d;
      odd_q        <= odd_d;
      pix_cnt_q    <= pix_cnt_d;
    end
  end

  // FIFO storage: returning SRAM data is captured in the cycle it arrives.
  always_ff @(posedge Clock) begin
    if (!reset && fifo_wr) begin
      fifo_mem_q[wr_ptr_q] <= bus.SRAM_read_data;
    end
  end

`ifdef RGB_READER_CKSUM_EN
  logic [15:0] cksum_q, cksum_d;

  // Running sum of FIFO writes, restarted by each accepted start.
  always_comb begin
    cksum_d = cksum_q;
    if (start_acc) begin
      cksum_d = '0;
    end else if (fifo_wr) begin
      cksum_d = cksum_q + bus.SRAM_read_data;
    end
  end

  // Checksum register.
  always_ff @(posedge Clock) begin
    if (reset) begin
      cksum_q <= '0;
    end else begin
      cksum_q <= cksum_d;
    end
  end

  assign checksum = cksum_q;
`else
  // Checksum port and accumulator are not built in this configuration.
`endif

  assign bus.SRAM_address = addr_q;
  assign bus.SRAM_we_n    = 1'b1;
  assign bus.pixel_R      = pix_r_q;
  assign bus.pixel_G      = pix_g_q;
  assign bus.pixel_B      = pix_b_q;
  assign bus.pixel_valid  = pix_valid_q;
  assign busy             = busy_q;
  assign frame_done       = frame_done_q;

endmodule

`default_nettype wire
